// File: rtl/acc_dispatch.sv
// Accelerator command dispatcher: queues core commands in a small FIFO and issues
// each one to a free accelerator channel, round-robin, with per-channel busy tracking.
module acc_dispatch #(
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 4,
    parameter int DW     = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    input  logic [DW-1:0]            cmd_instr,
    input  logic [DW-1:0]            cmd_startaddr,
    input  logic [DW-1:0]            cmd_datasize,
    output logic                     cmd_ready,
    output logic [NUM_CH-1:0]        acc_start,
    output logic [DW-1:0]            acc_instr,
    output logic [DW-1:0]            acc_startaddr,
    output logic [DW-1:0]            acc_datasize,
    input  logic [NUM_CH-1:0]        acc_done,
    output logic [NUM_CH-1:0]        ch_busy,
    output logic                     accbypass,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     err_sticky
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int RW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [3*DW-1:0]   mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic [RW-1:0]     rr_q, rr_d;
    logic [NUM_CH-1:0] busy_q, busy_d;
    logic [NUM_CH-1:0] start_q, start_d;
    logic [DW-1:0]     instr_q, addr_q, size_q;
    logic              err_q;

    logic              push;
    logic              dispatch;
    logic [RW-1:0]     winner;
    logic [NUM_CH-1:0] idle;
    logic [3*DW-1:0]   head;
    logic              err_set;

    // Space freed by a same-cycle pop is not offered to the push in that cycle.
    assign cmd_ready = (count_q != CW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign idle      = ~busy_q | acc_done;
    assign head      = mem_q[rd_ptr_q];
    assign err_set   = (cmd_valid && !cmd_ready) || (|(acc_done & ~busy_q));

    // First idle channel at or after rr_q, wrapping.
    always_comb begin
        logic [RW-1:0] idx;
        dispatch = 1'b0;
        winner   = '0;
        idx      = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = RW'((int'(rr_q) + k) % NUM_CH);
            if (!dispatch && (count_q != '0) && idle[idx]) begin
                dispatch = 1'b1;
                winner   = idx;
            end
        end
    end

    // A done on the channel being re-dispatched this edge leaves it busy.
    always_comb begin
        busy_d  = busy_q & ~acc_done;
        start_d = '0;
        rr_d    = rr_q;
        if (dispatch) begin
            busy_d[winner]  = 1'b1;
            start_d[winner] = 1'b1;
            rr_d = (int'(winner) == NUM_CH - 1) ? '0 : winner + RW'(1);
        end
        count_d = count_q + CW'(push) - CW'(dispatch);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {cmd_instr, cmd_startaddr, cmd_datasize};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rr_q     <= '0;
            busy_q   <= '0;
            start_q  <= '0;
            instr_q  <= '0;
            addr_q   <= '0;
            size_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            if (push)     wr_ptr_q <= wr_ptr_q + PW'(1);
            if (dispatch) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
                instr_q  <= head[3*DW-1:2*DW];
                addr_q   <= head[2*DW-1:DW];
                size_q   <= head[DW-1:0];
            end
            count_q <= count_d;
            rr_q    <= rr_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            if (err_set) err_q <= 1'b1;
        end
    end

    assign acc_start     = start_q;
    assign acc_instr     = instr_q;
    assign acc_startaddr = addr_q;
    assign acc_datasize  = size_q;
    assign ch_busy       = busy_q;
    assign fifo_count    = count_q;
    assign err_sticky    = err_q;
    assign accbypass     = (count_q == '0) && (start_q == '0) && (busy_q == '0);

endmodule

// File: tb/tb_acc_dispatch.sv
// Randomised and directed bench for acc_dispatch, checked against a queue-based
// reference model through an expected-start scoreboard.
module tb_acc_dispatch;

    localparam int NUM_CH = 2;
    localparam int DEPTH  = 4;
    localparam int DW     = 32;
    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int EW     = 8 + 3 * DW;

    logic              clk;
    logic              reset;
    logic              cmd_valid;
    logic [DW-1:0]     cmd_instr, cmd_startaddr, cmd_datasize;
    logic              cmd_ready;
    logic [NUM_CH-1:0] acc_start;
    logic [DW-1:0]     acc_instr, acc_startaddr, acc_datasize;
    logic [NUM_CH-1:0] acc_done;
    logic [NUM_CH-1:0] ch_busy;
    logic              accbypass;
    logic [CW-1:0]     fifo_count;
    logic              err_sticky;

    acc_dispatch #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_instr(cmd_instr),
        .cmd_startaddr(cmd_startaddr), .cmd_datasize(cmd_datasize),
        .cmd_ready(cmd_ready), .acc_start(acc_start),
        .acc_instr(acc_instr), .acc_startaddr(acc_startaddr), .acc_datasize(acc_datasize),
        .acc_done(acc_done), .ch_busy(ch_busy), .accbypass(accbypass),
        .fifo_count(fifo_count), .err_sticky(err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a command queue, a busy bit per channel, a round-robin index.
    logic [3*DW-1:0]   m_q[$];
    logic [EW-1:0]     exp_q[$];
    logic [NUM_CH-1:0] m_busy = '0;
    int                m_rr = 0;
    bit                m_err = 1'b0;
    bit                m_start = 1'b0;

    always @(posedge clk or negedge reset) begin : model
        int w;
        int c;
        bit full_now;
        if (!reset) begin
            m_q.delete();
            exp_q.delete();
            m_busy  = '0;
            m_rr    = 0;
            m_err   = 1'b0;
            m_start = 1'b0;
        end else begin
            full_now = (m_q.size() == DEPTH);
            w = -1;
            if (m_q.size() > 0) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    c = (m_rr + k) % NUM_CH;
                    if (w < 0 && (!m_busy[c] || acc_done[c])) w = c;
                end
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (acc_done[i]) begin
                    if (!m_busy[i]) m_err = 1'b1;
                    m_busy[i] = 1'b0;
                end
            end
            m_start = 1'b0;
            if (w >= 0) begin
                m_busy[w] = 1'b1;
                m_rr      = (w + 1) % NUM_CH;
                exp_q.push_back({8'(w), m_q.pop_front()});
                m_start   = 1'b1;
            end
            if (cmd_valid) begin
                if (full_now) m_err = 1'b1;
                else m_q.push_back({cmd_instr, cmd_startaddr, cmd_datasize});
            end
        end
    end

    // Monitor: compares status every cycle and pops the scoreboard on each start pulse.
    always @(negedge clk) begin : monitor
        logic [EW-1:0]     e;
        logic [NUM_CH-1:0] oh;
        chk("fifo_count", fifo_count, m_q.size());
        chk("ch_busy", ch_busy, m_busy);
        chk("cmd_ready", cmd_ready, m_q.size() != DEPTH);
        chk("err_sticky", err_sticky, m_err);
        chk("accbypass", accbypass, (m_q.size() == 0) && !m_start && (m_busy == '0));
        chk("start_pulse", acc_start != '0, m_start);
        if (!reset) chk("reset_payload", {acc_instr, acc_startaddr, acc_datasize}, '0);
        if (acc_start != '0) begin
            if (exp_q.size() == 0) begin
                chk("start_unexpected", acc_start, '0);
            end else begin
                e  = exp_q.pop_front();
                oh = '0;
                oh[e[EW-1 -: 8]] = 1'b1;
                chk("start_channel", acc_start, oh);
                chk("payload", {acc_instr, acc_startaddr, acc_datasize}, e[3*DW-1:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] i, input logic [DW-1:0] a, input logic [DW-1:0] s);
        cmd_valid = 1'b1;
        cmd_instr = i;
        cmd_startaddr = a;
        cmd_datasize = s;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic pulse_done(input logic [NUM_CH-1:0] m);
        acc_done = m;
        tick();
        acc_done = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        for (int i = 0; i < n; i++) begin
            cmd_valid     = 1'($urandom_range(0, 1));
            cmd_instr     = $urandom;
            cmd_startaddr = $urandom;
            cmd_datasize  = $urandom;
            acc_done      = NUM_CH'($urandom);
            tick();
        end
        cmd_valid = 1'b0;
        acc_done  = '0;
        tick();
        reset = 1'b1;
    endtask

    initial begin : driver
        reset = 1'b0;
        cmd_valid = 1'b0;
        cmd_instr = '0;
        cmd_startaddr = '0;
        cmd_datasize = '0;
        acc_done = '0;
        #1;
        do_reset(5);
        tick();
        chk("rst_bypass", accbypass, 1'b1);
        chk("rst_ready", cmd_ready, 1'b1);

        // Single command to channel 0, then completion.
        push(32'h0000_00A5, 32'h1000, 32'h40);
        tick();
        chk("single_start", acc_start, 2'b01);
        chk("single_instr", acc_instr, 32'h0000_00A5);
        chk("single_busy", ch_busy, 2'b01);
        tick();
        pulse_done(2'b01);
        chk("single_idle", ch_busy, 2'b00);
        chk("single_bypass", accbypass, 1'b1);

        // Round-robin: reset so the pointer starts at channel 0.
        do_reset(2);
        push(32'h11, 32'h100, 32'h1);
        push(32'h22, 32'h200, 32'h2);
        push(32'h33, 32'h300, 32'h3);
        chk("rr_second", acc_start, 2'b10);
        chk("rr_wait_count", fifo_count, 1);
        idle(2);
        chk("rr_still_wait", fifo_count, 1);
        pulse_done(2'b01);
        chk("rr_third_ch0", acc_start, 2'b01);
        chk("rr_third_instr", acc_instr, 32'h33);
        pulse_done(2'b11);

        // Backpressure with both channels occupied.
        push(32'h41, 32'h0, 32'h0);
        push(32'h42, 32'h0, 32'h0);
        idle(2);
        for (int i = 0; i < 4; i++) push(32'h50 + 32'(i), 32'h0, 32'h0);
        chk("full_ready", cmd_ready, 1'b0);
        chk("full_count", fifo_count, 4);
        push(32'h99, 32'h0, 32'h0);
        chk("overflow_err", err_sticky, 1'b1);
        chk("overflow_count", fifo_count, 4);

        // Done and re-dispatch on the same channel in the same cycle.
        do_reset(2);
        push(32'h61, 32'h0, 32'h0);
        push(32'h62, 32'h0, 32'h0);
        push(32'h63, 32'h0, 32'h0);
        pulse_done(2'b10);
        chk("simul_start", acc_start, 2'b10);
        chk("simul_busy", ch_busy, 2'b11);
        pulse_done(2'b11);
        idle(1);

        // Spurious done on an idle channel, then reset in the middle of a burst.
        pulse_done(2'b10);
        chk("spurious_err", err_sticky, 1'b1);
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd_instr = $urandom;
            tick();
        end
        reset = 1'b0;
        tick();
        cmd_valid = 1'b0;
        chk("midrst_count", fifo_count, 0);
        chk("midrst_start", acc_start, 2'b00);
        reset = 1'b1;
        tick();
        chk("release_start", acc_start, 2'b00);
        chk("release_err", err_sticky, 1'b0);

        // Random traffic; legal dones only, occasional overflow attempt.
        for (int n = 0; n < 500; n++) begin
            cmd_valid     = ($urandom_range(0, 2) != 0) &&
                            ((m_q.size() < DEPTH) || ($urandom_range(0, 60) == 0));
            cmd_instr     = $urandom;
            cmd_startaddr = $urandom;
            cmd_datasize  = $urandom;
            for (int c = 0; c < NUM_CH; c++)
                acc_done[c] = m_busy[c] && ($urandom_range(0, 2) == 0);
            tick();
        end
        cmd_valid = 1'b0;
        acc_done  = '0;

        // Drain with a bounded budget.
        for (int n = 0; n < 40; n++) begin
            if (m_q.size() == 0 && m_busy == '0 && !m_start) break;
            acc_done = m_busy;
            tick();
        end
        acc_done = '0;
        tick();
        chk("drain_bypass", accbypass, 1'b1);
        chk("drain_count", fifo_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
